// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - Configurable UART transmitter with tick generator, parity, 1.5/2 stop and break
//
// Purpose: pops words from a first-word-fall-through TX FIFO and serialises them
// LSB first with optional parity and 1 / 1.5 / 2 stop bits. It can also hold the line
// low for a break of at least one frame length.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   baud_div        clocks per oversample tick minus 1
//   num_data_bits   data bits per frame (0 or >DATA_W selects DATA_W)
//   parity          NONE / ODD / EVEN / MARK / SPACE
//   stop_bits       1 / 1.5 / 2
//   send_break      level request to hold the line low
//   tx_data         FIFO head word, valid while tx_empty=0
//   tx_empty        FIFO empty flag
//   tx_rden         FIFO pop strobe, one cycle per frame
//   tx              serial line, registered, idle high
//   tx_busy         low only while idle
//   tx_done         one-cycle pulse after each frame or break

package uart_pkg;
    typedef enum logic [2:0] {
        PARITY_NONE  = 3'd0,
        PARITY_ODD   = 3'd1,
        PARITY_EVEN  = 3'd2,
        PARITY_MARK  = 3'd3,
        PARITY_SPACE = 3'd4
    } parity_t;

    typedef enum logic [1:0] {
        STOP_BITS_1   = 2'd0,
        STOP_BITS_1P5 = 2'd1,
        STOP_BITS_2   = 2'd2
    } stop_bits_t;
endpackage

module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        num_data_bits,
    input  parity_t           parity,
    input  stop_bits_t        stop_bits,
    input  logic              send_break,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_empty,
    output logic              tx_rden,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);
    // Tick counter must reach the longest break minimum: (1 + DATA_W + 1) bits plus 2 stop bits.
    localparam int              TICK_W  = $clog2((DATA_W + 4) * OVERSAMPLE + 1);
    localparam logic [TICK_W-1:0] OS_T    = TICK_W'(OVERSAMPLE);
    localparam logic [TICK_W-1:0] OS_M1   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] OS_1P5  = TICK_W'(3 * OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] OS_2    = TICK_W'(2 * OVERSAMPLE);
    localparam logic [3:0]        DATA_W4 = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        nbits_q, nbits_d;
    parity_t           parity_q, parity_d;
    stop_bits_t        stop_q, stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pbit_q, pbit_d;
    logic              brk_stop_q, brk_stop_d;
    logic              tx_q, tx_d;
    logic              busy_q, rden_q;
    logic              done_q, done_d;

    logic [3:0]        nbits_in;
    logic [DATA_W-1:0] data_masked;
    logic              pbit_in;
    logic              active, tick, bit_end, stop_end, brk_done, last_bit;
    logic [TICK_W-1:0] stop_ticks, stop_len, frame_ticks;

    // Input-side helpers used when a frame or break configuration is captured.
    always_comb begin
        nbits_in = (num_data_bits == 4'd0 || num_data_bits > DATA_W4) ? DATA_W4 : num_data_bits;
        for (int i = 0; i < DATA_W; i++) begin
            data_masked[i] = tx_data[i] & (4'(i) < nbits_in);
        end
        case (parity)
            PARITY_ODD:  pbit_in = ~^data_masked;
            PARITY_EVEN: pbit_in = ^data_masked;
            PARITY_MARK: pbit_in = 1'b1;
            default:     pbit_in = 1'b0;
        endcase
    end

    // Timing helpers derived from the captured configuration.
    always_comb begin
        case (stop_q)
            STOP_BITS_1P5: stop_ticks = OS_1P5;
            STOP_BITS_2:   stop_ticks = OS_2;
            default:       stop_ticks = OS_T;
        endcase
        // The stop that closes a break is always a single bit.
        stop_len    = brk_stop_q ? OS_T : stop_ticks;
        frame_ticks = (TICK_W'(1) + TICK_W'(nbits_q) + TICK_W'(parity_q != PARITY_NONE)) * OS_T
                      + stop_ticks;
        active   = (state_q != S_IDLE) && (state_q != S_LOAD);
        tick     = active && (div_cnt_q == div_q);
        bit_end  = tick && (tick_cnt_q == OS_M1);
        stop_end = tick && (tick_cnt_q == stop_len - TICK_W'(1));
        // Saturated count, or the tick that completes the minimum length.
        brk_done = (tick_cnt_q >= frame_ticks) || (tick && (tick_cnt_q == frame_ticks - TICK_W'(1)));
        last_bit = (bit_cnt_q == nbits_q - 4'd1);
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pbit_d     = pbit_q;
        brk_stop_d = brk_stop_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        parity_d   = parity_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (send_break) begin
                    state_d = S_BREAK;
                end else if (!tx_empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d    = S_START;
                shift_d    = tx_data;
                pbit_d     = pbit_in;
                div_d      = baud_div;
                nbits_d    = nbits_in;
                parity_d   = parity;
                stop_d     = stop_bits;
                brk_stop_d = 1'b0;
                bit_cnt_d  = 4'd0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        state_d = (parity_q == PARITY_NONE) ? S_STOP : S_PARITY;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    done_d = 1'b1;
                    if (send_break) begin
                        state_d = S_BREAK;
                    end else if (!tx_empty) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (brk_done && !send_break) begin
                    state_d    = S_STOP;
                    brk_stop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A break sizes itself from the configuration present when it starts.
        if (state_d == S_BREAK && state_q != S_BREAK) begin
            div_d    = baud_div;
            nbits_d  = nbits_in;
            parity_d = parity;
            stop_d   = stop_bits;
        end

        // Divider free-runs while active; it restarts at frame/break start and when a break
        // is released, since the release is not aligned to a tick.
        if (active) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end
        if ((state_d == S_START || state_d == S_BREAK || state_d == S_STOP) && state_d != state_q) begin
            div_cnt_d = '0;
        end

        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            if (state_q == S_BREAK) begin
                tick_cnt_d = (tick_cnt_q >= frame_ticks) ? tick_cnt_q : tick_cnt_q + TICK_W'(1);
            end else if (state_q == S_DATA && bit_end) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end

        // Line value follows the state it is registered with.
        case (state_d)
            S_START, S_BREAK: tx_d = 1'b0;
            S_DATA:           tx_d = shift_d[0];
            S_PARITY:         tx_d = pbit_d;
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            nbits_q    <= '0;
            parity_q   <= PARITY_NONE;
            stop_q     <= STOP_BITS_1;
            shift_q    <= '0;
            pbit_q     <= 1'b0;
            brk_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            rden_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            parity_q   <= parity_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            pbit_q     <= pbit_d;
            brk_stop_q <= brk_stop_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != S_IDLE);
            rden_q     <= (state_d == S_LOAD);
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_rden = rden_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - Self-checking bench for uart_tx_cfg
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int DATA_W = 9;
    localparam int DIV_W  = 16;
    localparam int OS     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIV_W-1:0]  baud_div = '0;
    logic [3:0]        num_data_bits = 4'd8;
    parity_t           parity = PARITY_NONE;
    stop_bits_t        stop_bits = STOP_BITS_1;
    logic              send_break = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_empty = 1'b1;
    logic              tx_rden, tx, tx_busy, tx_done;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .num_data_bits(num_data_bits),
        .parity(parity), .stop_bits(stop_bits), .send_break(send_break), .tx_data(tx_data),
        .tx_empty(tx_empty), .tx_rden(tx_rden), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] fifo[$];
    bit   pop_pend = 1'b0;
    int   rden_cnt = 0, rden_empty = 0, done_cnt = 0;
    logic rec_tx[$], rec_done[$], rec_brk[$];
    logic exp_q[$];

    typedef struct {
        int         data;
        int         nbits;
        parity_t    par;
        stop_bits_t stop;
        int         div;
        int         exp_len;
    } vec_t;
    vec_t vecs[6];

    function automatic void refresh();
        tx_empty = (fifo.size() == 0);
        tx_data  = (fifo.size() > 0) ? fifo[0] : '0;
    endfunction

    function automatic void push(input int w);
        fifo.push_back(DATA_W'(w));
        refresh();
    endfunction

    // Line recorder, sampled away from the active edge.
    always @(negedge clk) begin
        rec_tx.push_back(tx);
        rec_done.push_back(tx_done);
        rec_brk.push_back(send_break);
        if (tx_rden === 1'b1) begin
            rden_cnt++;
            if (tx_empty) rden_empty++;
            pop_pend = 1'b1;
        end
        if (tx_done === 1'b1) done_cnt++;
    end

    // FIFO pops after the edge that ends the read cycle.
    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            pop_pend = 1'b0;
            if (fifo.size() > 0) void'(fifo.pop_front());
            refresh();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int eff_bits(input int n);
        return (n == 0 || n > DATA_W) ? DATA_W : n;
    endfunction

    function automatic int stop_ticks_of(input stop_bits_t s);
        return (s == STOP_BITS_1) ? OS : (s == STOP_BITS_1P5) ? (OS * 3) / 2 : 2 * OS;
    endfunction

    // Reference frame: each symbol held for (div+1)*OS clocks.
    function automatic void add_frame(input int data, input int n_in, input parity_t p,
                                      input stop_bits_t s, input int div);
        int   n, per, ones;
        logic v, pb;
        n    = eff_bits(n_in);
        per  = (div + 1) * OS;
        ones = 0;
        repeat (per) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            v = ((data >> i) & 1) != 0;
            if (v) ones++;
            repeat (per) exp_q.push_back(v);
        end
        if (p != PARITY_NONE) begin
            case (p)
                PARITY_ODD:  pb = (ones % 2) == 0;
                PARITY_EVEN: pb = (ones % 2) == 1;
                PARITY_MARK: pb = 1'b1;
                default:     pb = 1'b0;
            endcase
            repeat (per) exp_q.push_back(pb);
        end
        repeat (stop_ticks_of(s) * (div + 1)) exp_q.push_back(1'b1);
    endfunction

    function automatic int find_low(input int from);
        for (int i = from; i < rec_tx.size(); i++) if (rec_tx[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int find_done(input int from);
        for (int i = from; i < rec_done.size(); i++) if (rec_done[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic cmp_wave(input string name, input int st);
        int bad;
        bad = -1;
        checks++;
        if (st < 0 || st + exp_q.size() > rec_tx.size()) begin
            errors++;
            $display("FAIL %s window start=%0d needed=%0d recorded=%0d", name, st, exp_q.size(), rec_tx.size());
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && rec_tx[st + i] !== exp_q[i]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s tx sample %0d actual=%0b required=%0b", name, bad, rec_tx[st + bad], exp_q[bad]);
        end
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int t;
        t = 0;
        while (done_cnt < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout done_count actual=%0d required=%0d", name, done_cnt, target);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        rec_tx.delete();
        rec_done.delete();
        rec_brk.delete();
    endtask

    task automatic run_frame(input string name, input int data, input int n, input parity_t p,
                             input stop_bits_t s, input int div, input int exp_len, input bit chg);
        int d0, r0, st, t;
        @(posedge clk); #1;
        baud_div      = DIV_W'(div);
        num_data_bits = 4'(n);
        parity        = p;
        stop_bits     = s;
        clear_rec();
        d0 = done_cnt;
        r0 = rden_cnt;
        push(data);
        if (chg) begin
            t = 0;
            while (tx !== 1'b0 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            baud_div      = DIV_W'($urandom_range(0, 3));
            num_data_bits = 4'($urandom_range(0, 15));
            parity        = parity_t'($urandom_range(0, 4));
            stop_bits     = stop_bits_t'($urandom_range(0, 2));
        end
        wait_done(name, d0 + 1, 3000);
        exp_q.delete();
        add_frame(data, n, p, s, div);
        st = find_low(0);
        cmp_wave({name, "_wave"}, st);
        check({name, "_len"}, find_done(st) - st, exp_len);
        check({name, "_rden"}, rden_cnt - r0, 1);
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_idle"}, {tx_busy, tx}, 2'b01);
    endtask

    initial begin
        int d0, r0, st, bs, k, len, lmin;

        vecs[0] = '{32'h0A5, 8,  PARITY_NONE,  STOP_BITS_1,   0, 160};
        vecs[1] = '{32'h1FF, 7,  PARITY_EVEN,  STOP_BITS_2,   2, 528};
        vecs[2] = '{32'h100, 0,  PARITY_ODD,   STOP_BITS_1,   0, 192};
        vecs[3] = '{32'h03C, 8,  PARITY_MARK,  STOP_BITS_1P5, 1, 368};
        vecs[4] = '{32'h055, 5,  PARITY_SPACE, STOP_BITS_2,   0, 144};
        vecs[5] = '{32'h0F0, 12, PARITY_ODD,   STOP_BITS_1,   0, 192};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_rden", tx_rden, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].nbits, vecs[i].par,
                      vecs[i].stop, vecs[i].div, vecs[i].exp_len, 1'b0);
        end

        // Randomized frames with config changed mid-frame
        for (int i = 0; i < 8; i++) begin
            int rd, rn, rdiv;
            parity_t    rp;
            stop_bits_t rs;
            rd   = $urandom_range(0, 511);
            rn   = $urandom_range(0, 15);
            rp   = parity_t'($urandom_range(0, 4));
            rs   = stop_bits_t'($urandom_range(0, 2));
            rdiv = $urandom_range(0, 3);
            exp_q.delete();
            add_frame(rd, rn, rp, rs, rdiv);
            len = exp_q.size();
            run_frame($sformatf("rnd%0d", i), rd, rn, rp, rs, rdiv, len, 1'b1);
        end

        // Back-to-back words: one LOAD cycle between frames
        @(posedge clk); #1;
        baud_div = '0; num_data_bits = 4'd8; parity = PARITY_MARK; stop_bits = STOP_BITS_1P5;
        clear_rec();
        d0 = done_cnt; r0 = rden_cnt;
        push(9'h0C3);
        push(9'h012);
        wait_done("b2b", d0 + 2, 3000);
        exp_q.delete();
        add_frame(9'h0C3, 8, PARITY_MARK, STOP_BITS_1P5, 0);
        len = exp_q.size();
        exp_q.push_back(1'b1);
        add_frame(9'h012, 8, PARITY_MARK, STOP_BITS_1P5, 0);
        st = find_low(0);
        cmp_wave("b2b_wave", st);
        check("b2b_gap", find_low(st + len) - (st + len), 1);
        check("b2b_rden", rden_cnt - r0, 2);
        check("b2b_done", done_cnt - d0, 2);

        // Break requested mid-DATA, released after 300 clocks
        @(posedge clk); #1;
        baud_div = '0; num_data_bits = 4'd8; parity = PARITY_NONE; stop_bits = STOP_BITS_1;
        clear_rec();
        d0 = done_cnt; r0 = rden_cnt;
        push(9'h0A5);
        k = 0;
        while (tx !== 1'b0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (40) @(posedge clk);
        #1;
        send_break = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        send_break = 1'b0;
        wait_done("brk", d0 + 2, 3000);
        exp_q.delete();
        add_frame(9'h0A5, 8, PARITY_NONE, STOP_BITS_1, 0);
        st = find_low(0);
        cmp_wave("brk_frame", st);
        bs = st + 160;
        k = -1;
        for (int i = bs; i < rec_brk.size(); i++) if (k < 0 && rec_brk[i] === 1'b0) k = i;
        len = (k - bs + 1 > 160) ? k - bs + 1 : 160;
        exp_q.delete();
        repeat (len) exp_q.push_back(1'b0);
        repeat (OS) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        cmp_wave("brk_line", bs);
        check("brk_frame_done_at", find_done(st) - st, 160);
        check("brk_done_at", find_done(bs + 1) - bs, len + OS);
        check("brk_done", done_cnt - d0, 2);
        check("brk_rden", rden_cnt - r0, 1);

        // Short break pulse from idle stretches to one frame of the live config
        @(posedge clk); #1;
        baud_div = DIV_W'(1); num_data_bits = 4'd7; parity = PARITY_EVEN; stop_bits = STOP_BITS_2;
        clear_rec();
        d0 = done_cnt; r0 = rden_cnt;
        send_break = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_break = 1'b0;
        wait_done("brkmin", d0 + 1, 3000);
        lmin = ((1 + 7 + 1) * OS + 2 * OS) * 2;
        exp_q.delete();
        repeat (lmin) exp_q.push_back(1'b0);
        repeat (OS * 2) exp_q.push_back(1'b1);
        st = find_low(0);
        cmp_wave("brkmin_wave", st);
        check("brkmin_len", find_done(st) - st, lmin + OS * 2);
        check("brkmin_rden", rden_cnt - r0, 0);

        // Reset mid-DATA abandons the frame; the next word goes out cleanly
        @(posedge clk); #1;
        baud_div = '0; num_data_bits = 4'd8; parity = PARITY_NONE; stop_bits = STOP_BITS_1;
        r0 = rden_cnt;
        push(9'h0F0);
        push(9'h05A);
        k = 0;
        while (tx !== 1'b0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", tx_busy, 0);
        check("rstmid_rden_before", rden_cnt - r0, 1);
        repeat (3) @(posedge clk);
        #1;
        clear_rec();
        d0 = done_cnt; r0 = rden_cnt;
        rst_n = 1'b1;
        wait_done("rstmid", d0 + 1, 3000);
        exp_q.delete();
        add_frame(9'h05A, 8, PARITY_NONE, STOP_BITS_1, 0);
        st = find_low(0);
        cmp_wave("rstmid_wave", st);
        check("rstmid_rden_after", rden_cnt - r0, 1);
        check("rstmid_fifo_empty", fifo.size(), 0);

        check("rden_on_empty", rden_empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
